// File: rtl/systolic_matmul_nxn_stream.sv
// NxN output-stationary systolic matrix multiplier, C = A * B.
// Operands stream in one k-slice per beat and are skewed internally. Result rows
// drain over a valid/ready port once the array has flushed.
module systolic_matmul_nxn_stream #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int KMAX   = 16,
  parameter int KW     = $clog2(KMAX + 1),
  parameter int AW     = 2 * DW + $clog2(KMAX),
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DW-1:0]       a_col,
  input  logic [N*DW-1:0]       b_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*AW-1:0]       out_row,
  output logic [$clog2(N):0]    out_row_idx,
  output logic                  done
);

  localparam int RW         = $clog2(N) + 1;
  localparam int DCW        = $clog2(2 * N) + 1;
  localparam int DRAIN_LAST = (N > 1) ? (2 * N - 3) : 0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   r_beat_cnt;
  logic [DCW-1:0]  r_drain_cnt;
  logic [RW-1:0]   r_row_idx;

  logic [KW-1:0]   w_k_eff;
  logic [KW-1:0]   w_beat_nxt;
  logic            w_clr;
  logic            w_en;
  logic            w_load_last;
  logic            w_drain_last;
  logic            w_out_fire;
  logic            w_last_row;

  // Operand entering PE(i,j) from the west / north, and every accumulator.
  logic [DW-1:0]   w_a [N][N];
  logic [DW-1:0]   w_b [N][N];
  logic [DW-1:0]   w_a_src [N];
  logic [DW-1:0]   w_b_src [N];
  logic [AW-1:0]   w_acc [N][N];

  // Product of two operands, extended per SIGNED into the accumulator width.
  // The low 2*DW bits of the product are the same for both interpretations
  // once the operands are extended accordingly.
  function automatic logic [AW-1:0] mac_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] sa;
    logic signed [2*DW-1:0] sb;
    logic signed [2*DW-1:0] p;
    if (SIGNED != 0) begin
      sa = {{DW{a[DW-1]}}, a};
      sb = {{DW{b[DW-1]}}, b};
    end else begin
      sa = {{DW{1'b0}}, a};
      sb = {{DW{1'b0}}, b};
    end
    p = sa * sb;
    if (SIGNED != 0) return AW'(p);
    return AW'($unsigned(p));
  endfunction

  assign w_k_eff      = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  assign w_beat_nxt   = r_beat_cnt + KW'(1);
  assign w_clr        = (r_state == S_IDLE) && start;
  assign w_en         = ((r_state == S_LOAD) && in_valid) || (r_state == S_DRAIN);
  assign w_load_last  = (r_state == S_LOAD) && in_valid && (w_beat_nxt == r_k);
  assign w_drain_last = (r_drain_cnt == DCW'(DRAIN_LAST));
  assign w_out_fire   = (r_state == S_OUT) && out_ready;
  assign w_last_row   = (r_row_idx == RW'(N - 1));

  assign busy        = (r_state != S_IDLE);
  assign in_ready    = (r_state == S_LOAD);
  assign out_valid   = (r_state == S_OUT);
  assign out_row_idx = r_row_idx;
  assign done        = w_out_fire && w_last_row;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> LOAD -> DRAIN -> OUT -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (w_k_eff == '0) ? S_OUT : S_LOAD;
      end
      S_LOAD: begin
        if (w_load_last) w_state_nxt = (N == 1) ? S_OUT : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (w_out_fire && w_last_row) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job length, beat, drain and output-row counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k         <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_row_idx   <= '0;
    end else begin
      if (w_clr) begin
        r_k         <= w_k_eff;
        r_beat_cnt  <= '0;
        r_drain_cnt <= '0;
        r_row_idx   <= '0;
      end
      if ((r_state == S_LOAD) && in_valid) r_beat_cnt <= w_beat_nxt;
      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + DCW'(1);
      if (w_out_fire) r_row_idx <= w_last_row ? '0 : (r_row_idx + RW'(1));
    end
  end

  // Edge skew: row i of A and column j of B are delayed by i / j enable ticks.
  // Outside LOAD zeros are injected so the array drains cleanly.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    assign w_a_src[gi] = (r_state == S_LOAD) ? a_col[gi*DW +: DW] : '0;
    assign w_b_src[gi] = (r_state == S_LOAD) ? b_row[gi*DW +: DW] : '0;
    if (gi == 0) begin : g_nodly
      assign w_a[0][0] = w_a_src[0];
      assign w_b[0][0] = w_b_src[0];
    end else begin : g_dly
      logic [DW-1:0] r_ska [gi];
      logic [DW-1:0] r_skb [gi];
      // Skew shift registers, advanced only on array enable.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < gi; d++) begin
            r_ska[d] <= '0;
            r_skb[d] <= '0;
          end
        end else if (w_clr) begin
          for (int d = 0; d < gi; d++) begin
            r_ska[d] <= '0;
            r_skb[d] <= '0;
          end
        end else if (w_en) begin
          r_ska[0] <= w_a_src[gi];
          r_skb[0] <= w_b_src[gi];
          for (int d = 1; d < gi; d++) begin
            r_ska[d] <= r_ska[d-1];
            r_skb[d] <= r_skb[d-1];
          end
        end
      end
      assign w_a[gi][0] = r_ska[gi-1];
      assign w_b[0][gi] = r_skb[gi-1];
    end
  end

  // Processing-element grid.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic [AW-1:0] r_acc;
      // Multiply-accumulate on every enable tick.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_acc <= '0;
        else if (w_clr) r_acc <= '0;
        else if (w_en)  r_acc <= r_acc + mac_prod(w_a[gi][gj], w_b[gi][gj]);
      end
      assign w_acc[gi][gj] = r_acc;

      if (gj < N - 1) begin : g_east
        logic [DW-1:0] r_a;
        // Forward A one PE east per enable tick.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)       r_a <= '0;
          else if (w_clr) r_a <= '0;
          else if (w_en)  r_a <= w_a[gi][gj];
        end
        assign w_a[gi][gj+1] = r_a;
      end

      if (gi < N - 1) begin : g_south
        logic [DW-1:0] r_b;
        // Forward B one PE south per enable tick.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)       r_b <= '0;
          else if (w_clr) r_b <= '0;
          else if (w_en)  r_b <= w_b[gi][gj];
        end
        assign w_b[gi+1][gj] = r_b;
      end
    end
  end

  // Result row mux; the port reads zero outside OUT.
  always_comb begin
    out_row = '0;
    if (r_state == S_OUT) begin
      for (int r = 0; r < N; r++) begin
        if (r_row_idx == RW'(r)) begin
          for (int j = 0; j < N; j++) out_row[j*AW +: AW] = w_acc[r][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_nxn_stream.sv
// Bench for systolic_matmul_nxn_stream: an unsigned and a signed instance share
// stimulus; expected rows come from a plain matrix product over the driven data.
module tb_systolic_matmul_nxn_stream;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int KMAX = 16;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int AW   = 2 * DW + $clog2(KMAX);
  localparam int RW   = $clog2(N) + 1;
  localparam int CW   = N * AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [N*DW-1:0] a_col = '0;
  logic [N*DW-1:0] b_row = '0;

  logic            busy_u, in_ready_u, out_valid_u, done_u;
  logic [CW-1:0]   out_row_u;
  logic [RW-1:0]   out_row_idx_u;
  logic            busy_s, in_ready_s, out_valid_s, done_s;
  logic [CW-1:0]   out_row_s;
  logic [RW-1:0]   out_row_idx_s;

  systolic_matmul_nxn_stream #(.N(N), .DW(DW), .KMAX(KMAX), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst_n), .start(start), .k_len(k_len), .busy(busy_u),
    .in_valid(in_valid), .in_ready(in_ready_u), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_row(out_row_u),
    .out_row_idx(out_row_idx_u), .done(done_u)
  );

  systolic_matmul_nxn_stream #(.N(N), .DW(DW), .KMAX(KMAX), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst_n), .start(start), .k_len(k_len), .busy(busy_s),
    .in_valid(in_valid), .in_ready(in_ready_s), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_row(out_row_s),
    .out_row_idx(out_row_idx_s), .done(done_s)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] A [N][KMAX];
  logic [DW-1:0] B [KMAX][N];
  logic [CW-1:0] exp_u [N];
  logic [CW-1:0] exp_s [N];

  int job_id = 0;
  int job_active = 0;
  int lat_exp = -1;
  int start_cyc = 0;

  int exp_row = 0;
  int seen_first = 0;
  int last_id = 0;
  logic          prev_hold = 1'b0;
  logic [CW-1:0] prev_row = '0;
  logic [RW-1:0] prev_idx = '0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: C = A * B over the first keff k-slices, both interpretations, mod 2^AW.
  task automatic compute_exp(input int keff);
    logic signed [63:0] su;
    logic signed [63:0] ss;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        su = '0;
        ss = '0;
        for (int k = 0; k < keff; k++) begin
          su += 64'(A[r][k]) * 64'(B[k][j]);
          ss += 64'($signed(A[r][k])) * 64'($signed(B[k][j]));
        end
        exp_u[r][j*AW +: AW] = su[AW-1:0];
        exp_s[r][j*AW +: AW] = ss[AW-1:0];
      end
    end
  endtask

  task automatic fill_t1();
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        A[i][k] = (i == k) ? DW'(1) : DW'(0);
        B[k][i] = DW'(k * N + i + 1);
      end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        A[i][k] = av;
        B[k][i] = bv;
      end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        A[i][k] = DW'($urandom);
        B[k][i] = DW'($urandom);
      end
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) begin
      a_col[i*DW +: DW] = A[i][k];
      b_row[i*DW +: DW] = B[k][i];
    end
  endtask

  // bmode: 0 no bubbles, 1 alternate starting with a bubble, 2 random.
  // rmode: 0 always ready, 1 random ready, 2 hold off for 5 valid cycles.
  task automatic run_job(input int kl, input int bmode, input int rmode, input int lat);
    int keff;
    int k;
    int guard;
    int vcnt;
    logic fire;
    keff = (kl > KMAX) ? KMAX : kl;
    compute_exp(keff);
    guard = 0;
    while (busy_u && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    k_len = KW'(kl);
    start = 1'b1;
    lat_exp = lat;
    job_id++;
    job_active = 1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
    check("busy_after_start", CW'({busy_u, busy_s}), CW'(2'b11));
    k = 0;
    guard = 0;
    while (k < keff && guard < 1000) begin
      case (bmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2) == 1;
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      drive_beat(k);
      fire = in_valid && in_ready_u;
      @(posedge clk); #1;
      if (fire) k++;
      guard++;
    end
    if (k < keff) check("load_timeout", CW'(k), CW'(keff));
    check("in_ready_after_load", CW'({in_ready_u, in_ready_s}), CW'(0));
    guard = 0;
    vcnt = 0;
    while (exp_row < N && guard < 3000) begin
      start = (guard == 0);
      k_len = KW'($urandom_range(1, KMAX));
      in_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = DW'($urandom);
        b_row[i*DW +: DW] = DW'($urandom);
      end
      if (out_valid_u) vcnt++;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (vcnt > 5);
      endcase
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    k_len = '0;
    if (exp_row < N) check("out_timeout", CW'(exp_row), CW'(N));
    job_active = 0;
  endtask

  // Compare process: checks every result row, index, done and latency.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (job_id != last_id) begin
          last_id = job_id;
          exp_row = 0;
          seen_first = 0;
          prev_hold = 1'b0;
        end
        if (job_active != 0 && exp_row < N) begin
          if (out_valid_u) begin
            if (seen_first == 0) begin
              seen_first = 1;
              if (lat_exp >= 0) check("latency", CW'(cyc - start_cyc + 1), CW'(lat_exp));
            end
            check("out_valid_s", CW'(out_valid_s), CW'(1));
            check("row_idx_u", CW'(out_row_idx_u), CW'(exp_row));
            check("row_idx_s", CW'(out_row_idx_s), CW'(exp_row));
            check("out_row_u", out_row_u, exp_u[exp_row]);
            check("out_row_s", out_row_s, exp_s[exp_row]);
            check("done_u", CW'(done_u), CW'(out_ready && exp_row == N - 1));
            check("done_s", CW'(done_s), CW'(out_ready && exp_row == N - 1));
            if (prev_hold) begin
              check("hold_row", out_row_u, prev_row);
              check("hold_idx", CW'(out_row_idx_u), CW'(prev_idx));
            end
            prev_hold = !out_ready;
            prev_row = out_row_u;
            prev_idx = out_row_idx_u;
            if (out_ready) exp_row++;
          end else begin
            check("no_done_before_out", CW'({done_u, done_s, out_valid_s}), CW'(0));
            if (seen_first != 0) check("out_valid_dropped", CW'(out_valid_u), CW'(1));
          end
        end else begin
          check("idle_outputs", CW'({out_valid_u, out_valid_s, done_u, done_s}), CW'(0));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", CW'({busy_u, in_ready_u, out_valid_u, done_u,
                             busy_s, in_ready_s, out_valid_s, done_s}), CW'(0));
    check("reset_row_u", out_row_u, CW'(0));
    check("reset_idx", CW'({out_row_idx_u, out_row_idx_s}), CW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity A, B = 1..16 row-major.
    fill_t1();
    run_job(4, 0, 0, 11);
    check("pin_t1_c00", CW'(exp_u[0][AW-1:0]), CW'(1));
    check("pin_t1_c12", CW'(exp_u[1][2*AW +: AW]), CW'(7));
    check("pin_t1_c33", CW'(exp_u[3][3*AW +: AW]), CW'(16));

    // Same data with alternating bubbles: LOAD spans 8 cycles.
    run_job(4, 1, 0, 15);

    // -1 * 2 summed four times.
    fill_const(16'hFFFF, 16'h0002);
    run_job(4, 0, 1, 11);
    check("pin_signed_m8", CW'(exp_s[2][AW +: AW]), CW'(36'hFFFFFFFF8));
    check("pin_unsigned", CW'(exp_u[0][AW-1:0]), CW'(36'h00007FFF8));

    // Back-pressure on the first row.
    fill_rand();
    run_job(3, 0, 2, 10);

    // Full-length accumulation without wrap.
    fill_const(16'h7FFF, 16'h7FFF);
    run_job(16, 0, 0, 23);
    check("pin_kmax", CW'(exp_u[2][AW +: AW]), CW'(36'h3FFF00010));
    check("pin_kmax_s", CW'(exp_s[3][3*AW +: AW]), CW'(36'h3FFF00010));

    // k_len = 0 gives all-zero rows straight away.
    run_job(0, 0, 1, 1);
    check("pin_k0", exp_u[1], CW'(0));

    // k_len above KMAX is clamped.
    fill_rand();
    run_job(20, 0, 0, 23);

    // Reset after two LOAD beats, then rerun the identity job.
    fill_t1();
    k_len = KW'(4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    drive_beat(0);
    @(posedge clk); #1;
    drive_beat(1);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", CW'({busy_u, in_ready_u, out_valid_u, done_u,
                                busy_s, in_ready_s, out_valid_s, done_s}), CW'(0));
    check("midreset_row", CW'({out_row_u, out_row_idx_u}), CW'(0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(4, 0, 0, 11);

    // Random jobs with random bubbles and back-pressure.
    repeat (6) begin
      fill_rand();
      run_job(int'($urandom_range(1, KMAX)), 2, 1, -1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
